pwm_peripheral: RTL and testbench

- Consumes the five configuration registers written over SPI (output enables, PWM enables, duty cycle) and drives the 16 chip outputs.
- Each output is either forced low, driven static high, or driven with a shared PWM waveform.
- A prescaler and an 8-bit period counter generate the waveform.
- Duty-cycle changes are shadowed so they take effect only at a period boundary, which keeps periods glitch-free.

---
 rtl/pwm_peripheral_if.sv | 18 +
 rtl/pwm_peripheral.sv | 43 ++++
 tb/tb_pwm_peripheral.sv | 136 +++++++++++++
 3 files changed

// File: rtl/pwm_peripheral_if.sv
// pwm_peripheral_if: configuration registers in, chip outputs and period strobe out
interface pwm_peripheral_if;
   logic [7:0]  en_reg_out_7_0;
   logic [7:0]  en_reg_out_15_8;
   logic [7:0]  en_reg_pwm_7_0;
   logic [7:0]  en_reg_pwm_15_8;
   logic [7:0]  pwm_duty_cycle;
   logic [15:0] out;
   logic        period_start;
   modport master (
      output en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle,
      input  out, period_start
   );
   modport slave (
      input  en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle,
      output out, period_start
   );
endinterface

// File: rtl/pwm_peripheral.sv
// pwm_peripheral: prescaled 8-bit PWM shared by 16 outputs, each forced low, static high or PWM
module pwm_peripheral #(
   parameter int CLK_DIV = 13
) (
   input logic              clk,
   input logic              rst,
   pwm_peripheral_if.slave  bus
);
   localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   logic [PW-1:0] r_prescaler;
   logic [7:0]    r_pwm_cnt;
   logic [7:0]    r_duty_active;
   logic [15:0]   r_out;
   logic          r_period_start;
   logic          w_tick;
   logic          w_wrap;
   logic          w_level;
   logic [15:0]   w_en_out;
   logic [15:0]   w_en_pwm;
   assign w_tick   = r_prescaler == PW'(CLK_DIV - 1);
   assign w_wrap   = w_tick && r_pwm_cnt == 8'hFF;
   assign w_level  = r_duty_active == 8'hFF || r_pwm_cnt < r_duty_active;
   assign w_en_out = {bus.en_reg_out_15_8, bus.en_reg_out_7_0};
   assign w_en_pwm = {bus.en_reg_pwm_15_8, bus.en_reg_pwm_7_0};
   // duty is shadowed until the period boundary; enables are applied immediately
   always_ff @(posedge clk) begin
      if (rst) begin
         r_prescaler    <= '0;
         r_pwm_cnt      <= '0;
         r_duty_active  <= '0;
         r_out          <= '0;
         r_period_start <= 1'b0;
      end else begin
         r_prescaler    <= w_tick ? '0 : r_prescaler + PW'(1);
         r_pwm_cnt      <= w_tick ? r_pwm_cnt + 8'd1 : r_pwm_cnt;
         r_duty_active  <= w_wrap ? bus.pwm_duty_cycle : r_duty_active;
         r_period_start <= w_wrap;
         r_out          <= w_en_out & (~w_en_pwm | {16{w_level}});
      end
   end
   assign bus.out          = r_out;
   assign bus.period_start = r_period_start;
endmodule

// File: tb/tb_pwm_peripheral.sv
// tb_pwm_peripheral: directed plus randomized checks against a period-arithmetic reference model
module tb_pwm_peripheral;
   localparam int D = 13;
   localparam int P = 256 * D;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   pwm_peripheral_if bus ();
   pwm_peripheral #(.CLK_DIV(D)) dut (.clk(clk), .rst(rst), .bus(bus));
   int compared = 0;
   int mismatched = 0;
   int k = 0;
   logic [7:0]  duty_act = 8'h00;
   logic [15:0] exp_out = 16'h0000;
   logic        exp_ps = 1'b0;
   task automatic check(string tag, int obs, int exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   // k counts edges since reset; the period position follows directly from it
   task automatic step();
      logic [7:0]  cnt;
      logic        lvl;
      logic [15:0] eo;
      logic [15:0] ep;
      @(posedge clk);
      eo = {bus.en_reg_out_15_8, bus.en_reg_out_7_0};
      ep = {bus.en_reg_pwm_15_8, bus.en_reg_pwm_7_0};
      if (rst) begin
         k = 0;
         duty_act = 8'h00;
         exp_out = 16'h0000;
         exp_ps = 1'b0;
      end else begin
         cnt = 8'((k / D) % 256);
         lvl = duty_act == 8'hFF || cnt < duty_act;
         exp_out = eo & (~ep | {16{lvl}});
         k++;
         exp_ps = (k % P) == 0;
         if (exp_ps) duty_act = bus.pwm_duty_cycle;
      end
      #1;
      check("out", int'(bus.out), int'(exp_out));
      check("period_start", int'(bus.period_start), int'(exp_ps));
   endtask
   task automatic wait_ps(output int n);
      n = 0;
      do begin
         step();
         n++;
      end while (!bus.period_start && n < P + 100);
      check("ps_timeout", int'(bus.period_start), 1);
   endtask
   task automatic count_hi(input int idx, input int n, output int hi);
      hi = 0;
      for (int i = 0; i < n; i++) begin
         step();
         if (bus.out[idx]) hi++;
      end
   endtask
   task automatic set_en(input logic [7:0] o7, input logic [7:0] o15, input logic [7:0] p7, input logic [7:0] p15);
      bus.en_reg_out_7_0 = o7;
      bus.en_reg_out_15_8 = o15;
      bus.en_reg_pwm_7_0 = p7;
      bus.en_reg_pwm_15_8 = p15;
   endtask
   initial begin
      int n;
      int a;
      int b;
      logic [7:0] duties [3];
      int expect_hi [3];
      duties = '{8'h00, 8'hFF, 8'h01};
      expect_hi = '{0, P, D};
      set_en(8'h00, 8'h00, 8'h00, 8'h00);
      bus.pwm_duty_cycle = 8'h80;
      step();
      check("reset_out", int'(bus.out), 0);
      check("reset_ps", int'(bus.period_start), 0);
      rst = 1'b0;
      wait_ps(n);
      check("first_ps_delay", n, P);
      wait_ps(n);
      check("ps_interval", n, P);
      set_en(8'hA5, 8'h00, 8'h00, 8'h00);
      step();
      check("static_a5", int'(bus.out), 16'h00A5);
      for (int i = 0; i < 20; i++) step();
      check("static_a5_hold", int'(bus.out), 16'h00A5);
      set_en(8'h00, 8'hFF, 8'h00, 8'hFF);
      wait_ps(n);
      count_hi(15, P, a);
      check("duty80_high", a, P / 2);
      check("duty80_low_byte", int'(bus.out[7:0]), 0);
      set_en(8'h01, 8'h00, 8'h01, 8'h00);
      for (int j = 0; j < 3; j++) begin
         bus.pwm_duty_cycle = duties[j];
         wait_ps(n);
         count_hi(0, P, a);
         check("duty_boundary", a, expect_hi[j]);
      end
      bus.pwm_duty_cycle = 8'h40;
      wait_ps(n);
      count_hi(0, 8'h20 * D, a);
      bus.pwm_duty_cycle = 8'hC0;
      count_hi(0, P - 8'h20 * D, b);
      check("midchange_old_high", a + b, 8'h40 * D);
      check("midchange_boundary_ps", int'(bus.period_start), 1);
      count_hi(0, P, a);
      check("midchange_new_high", a, 8'hC0 * D);
      bus.pwm_duty_cycle = 8'h80;
      wait_ps(n);
      count_hi(0, 100, a);
      rst = 1'b1;
      step();
      check("midreset_out", int'(bus.out), 0);
      check("midreset_ps", int'(bus.period_start), 0);
      rst = 1'b0;
      count_hi(0, P, a);
      check("post_reset_low", a, 0);
      check("post_reset_ps", int'(bus.period_start), 1);
      count_hi(0, P, a);
      check("post_reset_resume", a, 8'h80 * D);
      for (int i = 0; i < 2 * P; i++) begin
         if ($urandom_range(0, 199) == 0)
            set_en(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
         if ($urandom_range(0, 299) == 0) bus.pwm_duty_cycle = 8'($urandom);
         step();
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
